fpu_issue_sequencer: RTL and testbench
======================================

FPU_ISSUE_SEQUENCER -- requirements
Module: fpu_issue_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles waiting on fpu_done before fault.
REQ-002 SHALL have ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- fpu_req  in  1  decoded instruction is an FPU op (not F_LW/F_SW).
- fpu_op  in  7  operation code from control unit.
- f_rd, f_rs1, f_rs2  in  3 each  FP register indices.
- f_frm  in  3  rounding mode.
- flush  in  1  pipeline flush (trap/branch).
- fpu_done  in  1  FPU result valid, single-cycle pulse.
- fpu_result  in  32  FPU result.
- fpu_start  out  1  one-cycle issue pulse to FPU.
- fpu_op_o  out  7  latched op.
- fpu_frm_o  out  3  latched rounding mode.
- stall  out  1  hold fetch/decode.
- f_wen  out  1  FP register-file write enable.
- f_waddr  out  3  write index.
- f_wdata  out  32  write data.
- busy_rd  out  8  scoreboard, bit n = FP reg n pending.
- fpu_fault  out  1  one-cycle pulse on timeout.

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT, WB.
REQ-004 IDLE: fpu_req=1 and no hazard -> latch fpu_op, f_frm, f_rd; set busy_rd[f_rd]; go ISSUE.
REQ-005 Hazard = busy_rd bit set for f_rs1, f_rs2 or f_rd; stall=1 while hazard and fpu_req=1 in IDLE.
REQ-006 ISSUE: fpu_start=1 for exactly one cycle; go WAIT next cycle; clear timeout counter.
REQ-007 WAIT: fpu_done=1 -> latch fpu_result, go WB; else increment 7-bit timeout counter.
REQ-008 Counter reaching TIMEOUT-1 without fpu_done -> pulse fpu_fault, clear busy_rd bit, go IDLE; no write.
REQ-009 WB: f_wen=1, f_waddr=latched rd, f_wdata=latched result, one cycle; clear busy_rd bit; go IDLE.
REQ-010 stall SHALL be 1 in ISSUE, WAIT, and in IDLE under REQ-005; 0 in WB and otherwise.
REQ-011 Issue-to-writeback latency SHALL be (cycles to fpu_done) + 2; minimum 3 cycles request-to-f_wen.
REQ-012 flush in ISSUE or WAIT: go IDLE next cycle, clear scoreboard bit, suppress write; fpu_done arriving that same cycle SHALL be discarded.
REQ-013 flush in WB SHALL NOT suppress the write (instruction already committed).
REQ-014 flush and fpu_req together in IDLE: flush wins, no issue.
REQ-015 fpu_done in IDLE or WB SHALL be ignored.
REQ-016 fpu_op_o/fpu_frm_o SHALL stay stable from ISSUE until return to IDLE.
REQ-017 Only one FPU op outstanding; busy_rd SHALL have at most one bit set.

Reset
REQ-018 RST=1 SHALL asynchronously force state IDLE, counter 0, busy_rd 0, fpu_start 0, stall 0, f_wen 0, f_waddr 0, f_wdata 0, fpu_op_o 0, fpu_frm_o 0, fpu_fault 0.
REQ-019 RST asserted mid-operation SHALL abandon the op; no write after release.

Structure
REQ-020 State enum fpu_seq_state_t and FPU_TIMEOUT_DEFAULT SHALL live in shared package fpu_types_pkg.
REQ-021 Scoreboard SHALL be sub-module fpu_scoreboard (set, clear, three-index hazard lookup).
REQ-022 All outputs SHALL be registered or decoded from state only; no fpu_done-to-f_wen combinational path.

Verification
REQ-023 fpu_req, op=7'h00, rd=2, fpu_done 3 cycles after fpu_start, result 32'h3F800000 -> f_wen one cycle, f_waddr=2, f_wdata=32'h3F800000, busy_rd 8'h04 then 8'h00.
REQ-024 Back-to-back req, second rs1=2 while rd=2 pending -> stall held until WB, second fpu_start the cycle after return to IDLE.
REQ-025 No fpu_done for 64 cycles -> fpu_fault pulses once on cycle 64 of WAIT, f_wen never asserted, busy_rd=0.
REQ-026 flush in WAIT coincident with fpu_done -> no f_wen, state IDLE, busy_rd=0.
REQ-027 RST pulsed during WAIT, fpu_done after release -> all outputs at reset values, no write.
REQ-028 fpu_req and flush same cycle in IDLE -> no fpu_start, stall=0.

Source files
------------

// File: rtl/fpu_types_pkg.sv
// Shared types for the FPU issue sequencer: the sequencer FSM states and the default
// completion timeout.
package fpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } fpu_seq_state_t;

    localparam int FPU_TIMEOUT_DEFAULT = 64;
    localparam int FPU_TMO_W           = 7;

endpackage

// File: rtl/fpu_scoreboard.sv
// Per-register pending bits for FP destinations, with hazard lookup on rs1/rs2/rd.
// Set/clear take effect on the next edge; the hazard output is combinational from the registered bits.
module fpu_scoreboard (
    input  logic       CLK,
    input  logic       RST,
    input  logic       set_vld,
    input  logic [2:0] set_idx,
    input  logic       clr_vld,
    input  logic [2:0] clr_idx,
    input  logic [2:0] rs1_idx,
    input  logic [2:0] rs2_idx,
    input  logic [2:0] rd_idx,
    output logic [7:0] busy,
    output logic       hazard
);

    logic [7:0] busy_q;
    logic [7:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_vld) busy_d[clr_idx] = 1'b0;
        if (set_vld) busy_d[set_idx] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) busy_q <= 8'h00;
        else     busy_q <= busy_d;
    end

    assign busy   = busy_q;
    assign hazard = busy_q[rs1_idx] | busy_q[rs2_idx] | busy_q[rd_idx];

endmodule

// File: rtl/fpu_issue_sequencer.sv
// Issues one FPU op at a time, waits for fpu_done (with timeout), then writes the FP regfile.
// Request to f_wen is at least 3 cycles; stall holds decode while an op is in flight or on a hazard.
module fpu_issue_sequencer
    import fpu_types_pkg::*;
#(
    parameter int TIMEOUT = FPU_TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        fpu_req,
    input  logic [6:0]  fpu_op,
    input  logic [2:0]  f_rd,
    input  logic [2:0]  f_rs1,
    input  logic [2:0]  f_rs2,
    input  logic [2:0]  f_frm,
    input  logic        flush,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        fpu_start,
    output logic [6:0]  fpu_op_o,
    output logic [2:0]  fpu_frm_o,
    output logic        stall,
    output logic        f_wen,
    output logic [2:0]  f_waddr,
    output logic [31:0] f_wdata,
    output logic [7:0]  busy_rd,
    output logic        fpu_fault
);

    localparam logic [FPU_TMO_W-1:0] TMO_LAST = FPU_TMO_W'(TIMEOUT - 1);

    fpu_seq_state_t       state_q, state_d;
    logic [FPU_TMO_W-1:0] cnt_q, cnt_d;
    logic [6:0]           op_q, op_d;
    logic [2:0]           frm_q, frm_d;
    logic [2:0]           rd_q, rd_d;
    logic [31:0]          res_q, res_d;
    logic                 fault_q, fault_d;

    logic sb_set, sb_clr, hazard;

    fpu_scoreboard u_scoreboard (
        .CLK     (CLK),
        .RST     (RST),
        .set_vld (sb_set),
        .set_idx (f_rd),
        .clr_vld (sb_clr),
        .clr_idx (rd_q),
        .rs1_idx (f_rs1),
        .rs2_idx (f_rs2),
        .rd_idx  (f_rd),
        .busy    (busy_rd),
        .hazard  (hazard)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        frm_d   = frm_q;
        rd_d    = rd_q;
        res_d   = res_q;
        fault_d = 1'b0;
        sb_set  = 1'b0;
        sb_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                // flush beats a simultaneous request
                if (fpu_req && !flush && !hazard) begin
                    op_d    = fpu_op;
                    frm_d   = f_frm;
                    rd_d    = f_rd;
                    sb_set  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (flush) begin
                    sb_clr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // flush is checked first so a same-cycle fpu_done is dropped
                if (flush) begin
                    sb_clr  = 1'b1;
                    state_d = IDLE;
                end else if (fpu_done) begin
                    res_d   = fpu_result;
                    state_d = WB;
                end else if (cnt_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    sb_clr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                sb_clr  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            frm_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            frm_q   <= frm_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            fault_q <= fault_d;
        end
    end

    assign fpu_start = (state_q == ISSUE);
    assign f_wen     = (state_q == WB);
    assign stall     = (state_q == ISSUE) || (state_q == WAIT) ||
                       ((state_q == IDLE) && fpu_req && hazard);
    assign f_waddr   = rd_q;
    assign f_wdata   = res_q;
    assign fpu_op_o  = op_q;
    assign fpu_frm_o = frm_q;
    assign fpu_fault = fault_q;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed bench for fpu_issue_sequencer: inputs driven on the falling edge, outputs sampled there.
module tb_fpu_issue_sequencer;
    import fpu_types_pkg::*;

    logic        CLK, RST, fpu_req, flush, fpu_done;
    logic [6:0]  fpu_op;
    logic [2:0]  f_rd, f_rs1, f_rs2, f_frm;
    logic [31:0] fpu_result;
    logic        fpu_start, stall, f_wen, fpu_fault;
    logic [6:0]  fpu_op_o;
    logic [2:0]  fpu_frm_o, f_waddr;
    logic [31:0] f_wdata;
    logic [7:0]  busy_rd;

    // {fpu_start, stall, f_wen, fpu_fault, busy_rd}
    logic [11:0] ctl;
    // {fpu_op_o, fpu_frm_o, f_waddr, f_wdata}
    logic [44:0] dat;
    assign ctl = {fpu_start, stall, f_wen, fpu_fault, busy_rd};
    assign dat = {fpu_op_o, fpu_frm_o, f_waddr, f_wdata};

    int checks = 0;
    int errors = 0;

    fpu_issue_sequencer #(.TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST), .fpu_req(fpu_req), .fpu_op(fpu_op),
        .f_rd(f_rd), .f_rs1(f_rs1), .f_rs2(f_rs2), .f_frm(f_frm),
        .flush(flush), .fpu_done(fpu_done), .fpu_result(fpu_result),
        .fpu_start(fpu_start), .fpu_op_o(fpu_op_o), .fpu_frm_o(fpu_frm_o),
        .stall(stall), .f_wen(f_wen), .f_waddr(f_waddr), .f_wdata(f_wdata),
        .busy_rd(busy_rd), .fpu_fault(fpu_fault)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic drive_idle();
        fpu_req = 0; flush = 0; fpu_done = 0; fpu_op = '0;
        f_rd = '0; f_rs1 = '0; f_rs2 = '0; f_frm = '0; fpu_result = '0;
    endtask

    task automatic drive_req(input logic [6:0] op, input logic [2:0] rd, rs1, rs2, frm);
        fpu_req = 1; fpu_op = op; f_rd = rd; f_rs1 = rs1; f_rs2 = rs2; f_frm = frm;
    endtask

    task automatic test_reset();
        RST = 1; drive_idle();
        @(negedge CLK);
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL reset_ctl got=%h exp=%h", ctl, 12'h000); end
        checks++; if (dat !== 45'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", dat); end
        RST = 0;
    endtask

    task automatic test_basic();
        @(negedge CLK); drive_req(7'h00, 3'd2, 3'd0, 3'd1, 3'd2); #1;
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL basic_accept got=%h exp=%h", ctl, 12'h000); end
        @(negedge CLK); fpu_req = 0;
        checks++; if (ctl !== {4'b1100, 8'h04}) begin errors++; $display("FAIL basic_issue got=%h exp=%h", ctl, {4'b1100, 8'h04}); end
        checks++; if ({fpu_op_o, fpu_frm_o} !== {7'h00, 3'd2}) begin errors++; $display("FAIL basic_latch got=%h exp=%h", {fpu_op_o, fpu_frm_o}, {7'h00, 3'd2}); end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++; if (ctl !== {4'b0100, 8'h04}) begin errors++; $display("FAIL basic_wait%0d got=%h exp=%h", i, ctl, {4'b0100, 8'h04}); end
        end
        @(negedge CLK); fpu_done = 1; fpu_result = 32'h3F800000; #1;
        checks++; if (ctl !== {4'b0100, 8'h04}) begin errors++; $display("FAIL basic_no_comb_wen got=%h exp=%h", ctl, {4'b0100, 8'h04}); end
        @(negedge CLK); fpu_done = 0; fpu_result = 32'hDEADBEEF;
        checks++; if (ctl !== {4'b0010, 8'h04}) begin errors++; $display("FAIL basic_wb got=%h exp=%h", ctl, {4'b0010, 8'h04}); end
        checks++; if (dat !== {7'h00, 3'd2, 3'd2, 32'h3F800000}) begin errors++; $display("FAIL basic_wdata got=%h exp=%h", dat, {7'h00, 3'd2, 3'd2, 32'h3F800000}); end
        @(negedge CLK);
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL basic_done got=%h exp=%h", ctl, 12'h000); end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK); drive_req(7'h10, 3'd2, 3'd0, 3'd1, 3'd1);
        @(negedge CLK); drive_req(7'h20, 3'd5, 3'd2, 3'd3, 3'd4); #1;
        checks++; if (ctl !== {4'b1100, 8'h04}) begin errors++; $display("FAIL b2b_issue1 got=%h exp=%h", ctl, {4'b1100, 8'h04}); end
        @(negedge CLK);
        checks++; if (ctl !== {4'b0100, 8'h04}) begin errors++; $display("FAIL b2b_stall got=%h exp=%h", ctl, {4'b0100, 8'h04}); end
        checks++; if ({fpu_op_o, fpu_frm_o} !== {7'h10, 3'd1}) begin errors++; $display("FAIL b2b_op_stable got=%h exp=%h", {fpu_op_o, fpu_frm_o}, {7'h10, 3'd1}); end
        @(negedge CLK); fpu_done = 1; fpu_result = 32'h40000000; #1;
        checks++; if (ctl !== {4'b0100, 8'h04}) begin errors++; $display("FAIL b2b_stall2 got=%h exp=%h", ctl, {4'b0100, 8'h04}); end
        @(negedge CLK); fpu_done = 0;
        checks++; if (ctl !== {4'b0010, 8'h04}) begin errors++; $display("FAIL b2b_wb1 got=%h exp=%h", ctl, {4'b0010, 8'h04}); end
        checks++; if ({f_waddr, f_wdata} !== {3'd2, 32'h40000000}) begin errors++; $display("FAIL b2b_wdata1 got=%h exp=%h", {f_waddr, f_wdata}, {3'd2, 32'h40000000}); end
        @(negedge CLK);
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL b2b_idle got=%h exp=%h", ctl, 12'h000); end
        @(negedge CLK); fpu_req = 0;
        checks++; if (ctl !== {4'b1100, 8'h20}) begin errors++; $display("FAIL b2b_issue2 got=%h exp=%h", ctl, {4'b1100, 8'h20}); end
        checks++; if ({fpu_op_o, fpu_frm_o} !== {7'h20, 3'd4}) begin errors++; $display("FAIL b2b_latch2 got=%h exp=%h", {fpu_op_o, fpu_frm_o}, {7'h20, 3'd4}); end
        @(negedge CLK); fpu_done = 1; fpu_result = 32'h40400000;
        @(negedge CLK); fpu_done = 0;
        checks++; if (ctl !== {4'b0010, 8'h20}) begin errors++; $display("FAIL b2b_wb2 got=%h exp=%h", ctl, {4'b0010, 8'h20}); end
        checks++; if ({f_waddr, f_wdata} !== {3'd5, 32'h40400000}) begin errors++; $display("FAIL b2b_wdata2 got=%h exp=%h", {f_waddr, f_wdata}, {3'd5, 32'h40400000}); end
        @(negedge CLK); drive_idle();
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL b2b_end got=%h exp=%h", ctl, 12'h000); end
    endtask

    task automatic test_timeout();
        @(negedge CLK); drive_req(7'h05, 3'd3, 3'd0, 3'd0, 3'd0);
        @(negedge CLK); drive_idle();
        checks++; if (ctl !== {4'b1100, 8'h08}) begin errors++; $display("FAIL tmo_issue got=%h exp=%h", ctl, {4'b1100, 8'h08}); end
        for (int i = 1; i <= 64; i++) begin
            @(negedge CLK);
            checks++; if (ctl !== {4'b0100, 8'h08}) begin errors++; $display("FAIL tmo_wait%0d got=%h exp=%h", i, ctl, {4'b0100, 8'h08}); end
        end
        @(negedge CLK);
        checks++; if (ctl !== {4'b0001, 8'h00}) begin errors++; $display("FAIL tmo_fault got=%h exp=%h", ctl, {4'b0001, 8'h00}); end
        @(negedge CLK);
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL tmo_fault_once got=%h exp=%h", ctl, 12'h000); end
    endtask

    task automatic test_flush_wait_done();
        @(negedge CLK); drive_req(7'h11, 3'd6, 3'd0, 3'd1, 3'd0);
        @(negedge CLK); drive_idle();
        @(negedge CLK); flush = 1; fpu_done = 1; fpu_result = 32'h12345678;
        @(negedge CLK); drive_idle();
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL flushw_ctl got=%h exp=%h", ctl, 12'h000); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL flushw_state got=%0d exp=%0d", dut.state_q, IDLE); end
        @(negedge CLK);
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL flushw_nowrite got=%h exp=%h", ctl, 12'h000); end
    endtask

    task automatic test_flush_issue();
        @(negedge CLK); drive_req(7'h12, 3'd1, 3'd0, 3'd0, 3'd0);
        @(negedge CLK); fpu_req = 0; flush = 1;
        checks++; if (ctl !== {4'b1100, 8'h02}) begin errors++; $display("FAIL flushi_issue got=%h exp=%h", ctl, {4'b1100, 8'h02}); end
        @(negedge CLK); drive_idle();
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL flushi_idle got=%h exp=%h", ctl, 12'h000); end
        @(negedge CLK);
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL flushi_stay got=%h exp=%h", ctl, 12'h000); end
    endtask

    task automatic test_flush_wb();
        @(negedge CLK); drive_req(7'h13, 3'd4, 3'd0, 3'd0, 3'd0);
        @(negedge CLK); drive_idle();
        @(negedge CLK); fpu_done = 1; fpu_result = 32'hC0A00000;
        @(negedge CLK); fpu_done = 0; flush = 1; #1;
        checks++; if (ctl !== {4'b0010, 8'h10}) begin errors++; $display("FAIL flushwb_wen got=%h exp=%h", ctl, {4'b0010, 8'h10}); end
        checks++; if ({f_waddr, f_wdata} !== {3'd4, 32'hC0A00000}) begin errors++; $display("FAIL flushwb_wdata got=%h exp=%h", {f_waddr, f_wdata}, {3'd4, 32'hC0A00000}); end
        @(negedge CLK); drive_idle();
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL flushwb_idle got=%h exp=%h", ctl, 12'h000); end
    endtask

    task automatic test_done_idle();
        @(negedge CLK); fpu_done = 1; fpu_result = 32'hFFFFFFFF;
        @(negedge CLK); drive_idle();
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL doneidle_ctl got=%h exp=%h", ctl, 12'h000); end
        checks++; if (f_wdata !== 32'hC0A00000) begin errors++; $display("FAIL doneidle_wdata got=%h exp=%h", f_wdata, 32'hC0A00000); end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK); drive_req(7'h33, 3'd7, 3'd1, 3'd2, 3'd3);
        @(negedge CLK); drive_idle();
        @(negedge CLK);
        checks++; if (ctl !== {4'b0100, 8'h80}) begin errors++; $display("FAIL rstmid_wait got=%h exp=%h", ctl, {4'b0100, 8'h80}); end
        @(negedge CLK); RST = 1; #1;
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL rstmid_async_ctl got=%h exp=%h", ctl, 12'h000); end
        checks++; if (dat !== 45'h0) begin errors++; $display("FAIL rstmid_async_dat got=%h exp=0", dat); end
        @(negedge CLK); RST = 0; fpu_done = 1; fpu_result = 32'h55555555;
        @(negedge CLK); drive_idle();
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL rstmid_nowrite got=%h exp=%h", ctl, 12'h000); end
        checks++; if (dat !== 45'h0) begin errors++; $display("FAIL rstmid_dat got=%h exp=0", dat); end
        @(negedge CLK);
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL rstmid_stay got=%h exp=%h", ctl, 12'h000); end
    endtask

    task automatic test_req_flush_idle();
        @(negedge CLK); drive_req(7'h01, 3'd1, 3'd0, 3'd0, 3'd0); flush = 1; #1;
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL reqflush_stall got=%h exp=%h", ctl, 12'h000); end
        @(negedge CLK); drive_idle();
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL reqflush_nostart got=%h exp=%h", ctl, 12'h000); end
        @(negedge CLK);
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL reqflush_stay got=%h exp=%h", ctl, 12'h000); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_flush_wait_done();
        test_flush_issue();
        test_flush_wb();
        test_done_idle();
        test_reset_mid();
        test_req_flush_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
